// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared state encoding and defaults for the FIFO write arbiter
package fifo_arb_pkg;

  localparam int DEF_DATA_W = 32;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

endpackage

// File: rtl/fifo_write_arbiter_if.sv
// rtl/fifo_write_arbiter_if.sv - producer and FIFO write-side signals of the arbiter
interface fifo_write_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = fifo_arb_pkg::DEF_DATA_W
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        req_last;
  logic [NUM_REQ*DATA_W-1:0] req_din;
  logic [NUM_REQ-1:0]        req_ack;
  logic [NUM_REQ-1:0]        grant;
  logic [DATA_W-1:0]         fifo_din;
  logic                      fifo_writep;
  logic                      fifo_fullp;
  logic                      busy;

  modport slave (
    input  req, req_last, req_din, fifo_fullp,
    output req_ack, grant, fifo_din, fifo_writep, busy
  );

  modport master (
    output req, req_last, req_din, fifo_fullp,
    input  req_ack, grant, fifo_din, fifo_writep, busy
  );
endinterface

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational rotating-priority selector, first set bit after last_ptr
module rr_pick #(
  parameter int N     = 4,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] last_ptr,
  output logic [N-1:0]     win,
  output logic             valid
);

  logic             found;
  int               idx;
  logic [PTR_W-1:0] sel;

  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = 0;
    sel   = '0;
    // Scan last_ptr+1 .. last_ptr+N so the previous winner is considered last.
    for (int k = 1; k <= N; k++) begin
      idx = int'(last_ptr) + k;
      if (idx >= N) idx = idx - N;
      sel = PTR_W'(idx);
      if (!found && req[sel]) begin
        win[sel] = 1'b1;
        found    = 1'b1;
      end
    end
    valid = found;
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// rtl/fifo_write_arbiter.sv - round-robin burst arbiter sharing the FIFO write port
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_BURST = 16,
  parameter int CNT_W     = 5
) (
  input logic                 clk,
  input logic                 rstp,
  fifo_write_arbiter_if.slave bus
);

  localparam int PTR_W = $clog2(NUM_REQ);

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;
  logic [PTR_W-1:0]   last_ptr_q, last_ptr_d;
  logic               busy_q, busy_d;

  logic [NUM_REQ-1:0] pick_win;
  logic               pick_valid;
  logic [PTR_W-1:0]   g_idx;
  logic               g_req;
  logic               g_last;
  logic [DATA_W-1:0]  g_din;
  logic               wr_en;
  logic               in_burst;
  logic [CNT_W-1:0]   cnt_inc;
  logic [DATA_W-1:0]  din_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign din_arr[i] = bus.req_din[i*DATA_W +: DATA_W];
  end

  rr_pick #(.N(NUM_REQ), .PTR_W(PTR_W)) u_pick (
    .req      (bus.req),
    .last_ptr (last_ptr_q),
    .win      (pick_win),
    .valid    (pick_valid)
  );

  always_comb begin
    g_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) g_idx = PTR_W'(i);
    end
  end

  assign g_req    = bus.req[g_idx];
  assign g_last   = bus.req_last[g_idx];
  assign g_din    = din_arr[g_idx];
  assign in_burst = (state_q == ST_BURST) && !rstp;
  // Gating with rstp keeps a word acked in the reset cycle out of the FIFO.
  assign wr_en    = in_burst && g_req && !bus.fifo_fullp;
  assign cnt_inc  = burst_cnt_q + CNT_W'(1);

  assign bus.fifo_writep = wr_en;
  assign bus.fifo_din    = in_burst ? g_din : '0;
  assign bus.req_ack     = wr_en ? grant_q : '0;
  assign bus.grant       = grant_q;
  assign bus.busy        = busy_q;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    burst_cnt_d = burst_cnt_q;
    last_ptr_d  = last_ptr_q;
    busy_d      = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d     = ST_BURST;
          grant_d     = pick_win;
          burst_cnt_d = '0;
          busy_d      = 1'b1;
        end
      end
      ST_BURST: begin
        if ((wr_en && (g_last || cnt_inc == CNT_W'(MAX_BURST))) || !g_req) begin
          state_d     = ST_IDLE;
          grant_d     = '0;
          burst_cnt_d = '0;
          last_ptr_d  = g_idx;
          busy_d      = 1'b0;
        end else if (wr_en) begin
          burst_cnt_d = cnt_inc;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rstp) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      burst_cnt_q <= '0;
      last_ptr_q  <= PTR_W'(NUM_REQ - 1);
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      burst_cnt_q <= burst_cnt_d;
      last_ptr_q  <= last_ptr_d;
      busy_q      <= busy_d;
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb/tb_fifo_write_arbiter.sv - self-checking bench for fifo_write_arbiter
module tb_fifo_write_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int MB = 16;

  logic clk = 1'b0;
  logic rstp;
  always #5 clk = ~clk;

  fifo_write_arbiter_if #(.NUM_REQ(N), .DATA_W(DW)) ifc ();

  fifo_write_arbiter #(.NUM_REQ(N), .DATA_W(DW), .MAX_BURST(MB), .CNT_W(5)) dut (
    .clk  (clk),
    .rstp (rstp),
    .bus  (ifc)
  );

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] last;
    logic       full;
    logic [3:0] g;
    logic       wr;
    logic       busy;
  } vec_t;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] sb [$];
  logic [DW-1:0] rq_data [N][$];
  bit            rq_last [N][$];

  logic rst_req;
  int   full_after, full_len, full_cnt, wr_cnt;
  logic [N-1:0] prev_grant;
  int   idle_run;
  logic [N-1:0] cg;
  int   cw, cc, ci;
  logic [N-1:0] seg_g [$];
  int   seg_w [$];
  int   seg_c [$];
  int   seg_i [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pop_check();
    logic [DW-1:0] e;
    if (sb.size() == 0) begin
      check("unexpected_write", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check("fifo_din", ifc.fifo_din, e);
    end
  endtask

  function automatic vec_t mk(input logic rst, input logic [3:0] req, input logic [3:0] last,
                              input logic full, input logic [3:0] g, input logic wr,
                              input logic busy);
    vec_t v;
    v.rst = rst; v.req = req; v.last = last; v.full = full;
    v.g = g; v.wr = wr; v.busy = busy;
    return v;
  endfunction

  task automatic begin_scn();
    seg_g.delete(); seg_w.delete(); seg_c.delete(); seg_i.delete();
    prev_grant = '0;
    idle_run   = 0;
    wr_cnt     = 0;
    full_after = -1;
    full_len   = 0;
    full_cnt   = 0;
  endtask

  task automatic cycle();
    logic [N-1:0] cur;
    @(negedge clk);
    rstp = rst_req;
    ifc.fifo_fullp = (full_after >= 0) && (wr_cnt == full_after) && (full_cnt < full_len);
    if (ifc.fifo_fullp) full_cnt++;
    for (int i = 0; i < N; i++) begin
      ifc.req[i] = (rq_data[i].size() > 0);
      ifc.req_din[i*DW +: DW] = (rq_data[i].size() > 0) ? rq_data[i][0] : '0;
      ifc.req_last[i] = (rq_last[i].size() > 0) ? rq_last[i][0] : 1'b0;
    end
    #1;
    if (ifc.fifo_fullp) begin
      check("stall_writep", {31'd0, ifc.fifo_writep}, 32'd0);
      check("stall_ack", {28'd0, ifc.req_ack}, 32'd0);
    end
    if (rstp) check("reset_writep", {31'd0, ifc.fifo_writep}, 32'd0);
    if (ifc.fifo_writep) begin
      wr_cnt++;
      pop_check();
    end
    for (int i = 0; i < N; i++) begin
      if (ifc.req_ack[i]) begin
        if (rq_data[i].size() > 0) begin
          void'(rq_data[i].pop_front());
          void'(rq_last[i].pop_front());
        end else begin
          check("ack_without_req", 32'd1, 32'd0);
        end
      end
    end
    cur = ifc.grant;
    if (prev_grant != '0 && cur != prev_grant) begin
      seg_g.push_back(cg); seg_w.push_back(cw); seg_c.push_back(cc); seg_i.push_back(ci);
    end
    if (cur != '0) begin
      if (cur != prev_grant) begin
        cg = cur; cw = 0; cc = 0; ci = idle_run;
      end
      cc++;
      if (ifc.fifo_writep) cw++;
      idle_run = 0;
    end else begin
      idle_run++;
    end
    prev_grant = cur;
  endtask

  task automatic run_drain(input string name, input int budget);
    bit drained = 1'b0;
    bit empty;
    for (int c = 0; c < budget && !drained; c++) begin
      cycle();
      empty = 1'b1;
      for (int i = 0; i < N; i++) if (rq_data[i].size() > 0) empty = 1'b0;
      if (empty && ifc.grant == '0) drained = 1'b1;
    end
    check({name, "_drain_timeout"}, {31'd0, drained}, 32'd1);
    check({name, "_sb_empty"}, sb.size(), 32'd0);
  endtask

  task automatic check_seg(input string name, input int k, input logic [N-1:0] g,
                           input int w, input int c, input int idle);
    if (k >= seg_g.size()) begin
      check({name, "_seg_missing"}, k, seg_g.size());
    end else begin
      check({name, "_seg_grant"}, {28'd0, seg_g[k]}, {28'd0, g});
      check({name, "_seg_writes"}, seg_w[k], w);
      check({name, "_seg_cycles"}, seg_c[k], c);
      check({name, "_seg_idle"}, seg_i[k], idle);
    end
  endtask

  task automatic do_reset();
    for (int i = 0; i < N; i++) begin
      rq_data[i].delete();
      rq_last[i].delete();
    end
    rst_req = 1'b1;
    cycle();
    cycle();
    rst_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [19];
    logic [3:0] eack;
    int gi;

    rstp = 1'b1;
    rst_req = 1'b1;
    ifc.req = '0;
    ifc.req_last = '0;
    ifc.fifo_fullp = 1'b0;
    for (int i = 0; i < N; i++) ifc.req_din[i*DW +: DW] = 32'hA000_0000 + i;

    tbl[0]  = mk(1, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0);
    tbl[1]  = mk(1, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0);
    tbl[2]  = mk(0, 4'b0101, 4'b0000, 0, 4'b0000, 0, 0);
    tbl[3]  = mk(0, 4'b0101, 4'b0000, 0, 4'b0001, 1, 1);
    tbl[4]  = mk(0, 4'b0101, 4'b0000, 0, 4'b0001, 1, 1);
    tbl[5]  = mk(0, 4'b0101, 4'b0001, 0, 4'b0001, 1, 1);
    tbl[6]  = mk(0, 4'b0100, 4'b0000, 0, 4'b0000, 0, 0);
    tbl[7]  = mk(0, 4'b0100, 4'b0000, 0, 4'b0100, 1, 1);
    tbl[8]  = mk(0, 4'b0100, 4'b0000, 0, 4'b0100, 1, 1);
    tbl[9]  = mk(0, 4'b0100, 4'b0100, 0, 4'b0100, 1, 1);
    tbl[10] = mk(0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0);
    tbl[11] = mk(0, 4'b0010, 4'b0010, 0, 4'b0000, 0, 0);
    tbl[12] = mk(0, 4'b0010, 4'b0010, 0, 4'b0010, 1, 1);
    tbl[13] = mk(0, 4'b0101, 4'b0000, 0, 4'b0000, 0, 0);
    tbl[14] = mk(0, 4'b0101, 4'b0000, 0, 4'b0100, 1, 1);
    tbl[15] = mk(0, 4'b0001, 4'b0000, 0, 4'b0100, 0, 1);
    tbl[16] = mk(0, 4'b0001, 4'b0001, 0, 4'b0000, 0, 0);
    tbl[17] = mk(0, 4'b0001, 4'b0001, 0, 4'b0001, 1, 1);
    tbl[18] = mk(0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0);

    for (int v = 0; v < 19; v++) begin
      @(negedge clk);
      rstp = tbl[v].rst;
      ifc.req = tbl[v].req;
      ifc.req_last = tbl[v].last;
      ifc.fifo_fullp = tbl[v].full;
      #1;
      eack = tbl[v].wr ? tbl[v].g : 4'b0000;
      check($sformatf("tbl%0d_grant", v), {28'd0, ifc.grant}, {28'd0, tbl[v].g});
      check($sformatf("tbl%0d_writep", v), {31'd0, ifc.fifo_writep}, {31'd0, tbl[v].wr});
      check($sformatf("tbl%0d_ack", v), {28'd0, ifc.req_ack}, {28'd0, eack});
      check($sformatf("tbl%0d_busy", v), {31'd0, ifc.busy}, {31'd0, tbl[v].busy});
      if (tbl[v].g == 4'b0000) check($sformatf("tbl%0d_din_idle", v), ifc.fifo_din, 32'd0);
      if (tbl[v].wr) begin
        gi = 0;
        for (int i = 0; i < N; i++) if (tbl[v].g[i]) gi = i;
        sb.push_back(32'hA000_0000 + gi);
      end
      if (ifc.fifo_writep) pop_check();
    end
    check("tbl_sb_empty", sb.size(), 32'd0);

    // Single requester, 20 words, no last: forced split at MAX_BURST.
    do_reset();
    begin_scn();
    for (int k = 0; k < 20; k++) begin
      rq_data[1].push_back(32'h2000_0000 + k);
      rq_last[1].push_back(1'b0);
      sb.push_back(32'h2000_0000 + k);
    end
    run_drain("burst_limit", 100);
    check("burst_limit_nseg", seg_g.size(), 32'd2);
    check_seg("burst_limit", 0, 4'b0010, 16, 16, 1);
    check_seg("burst_limit", 1, 4'b0010, 4, 5, 1);
    check("burst_limit_writes", wr_cnt, 32'd20);

    // FIFO full for 5 cycles after the second word of requester 3.
    do_reset();
    begin_scn();
    for (int k = 0; k < 4; k++) begin
      rq_data[3].push_back(32'h3000_0000 + k);
      rq_last[3].push_back(k == 3);
      sb.push_back(32'h3000_0000 + k);
    end
    full_after = 2;
    full_len   = 5;
    run_drain("full_stall", 60);
    check("full_stall_cycles", full_cnt, 32'd5);
    check("full_stall_nseg", seg_g.size(), 32'd1);
    check_seg("full_stall", 0, 4'b1000, 4, 9, 1);

    // All four requesting continuously with single-word bursts.
    do_reset();
    begin_scn();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < N; i++) begin
        rq_data[i].push_back(32'h5000_0000 + (i << 4) + k);
        rq_last[i].push_back(1'b1);
        sb.push_back(32'h5000_0000 + (i << 4) + k);
      end
    end
    run_drain("rr", 80);
    check("rr_nseg", seg_g.size(), 32'd8);
    for (int s = 0; s < 8; s++) check_seg("rr", s, 4'b0001 << (s % 4), 1, 1, 1);

    // Reset during the second word of a 4-word burst.
    do_reset();
    begin_scn();
    for (int k = 0; k < 4; k++) begin
      rq_data[0].push_back(32'h6000_0000 + k);
      rq_last[0].push_back(k == 3);
    end
    sb.push_back(32'h6000_0000);
    for (int c = 0; c < 10 && wr_cnt < 1; c++) cycle();
    check("rst_mid_first_word", wr_cnt, 32'd1);
    rst_req = 1'b1;
    cycle();
    for (int i = 0; i < N; i++) begin
      rq_data[i].delete();
      rq_last[i].delete();
    end
    rst_req = 1'b0;
    cycle();
    check("rst_mid_grant", {28'd0, ifc.grant}, 32'd0);
    check("rst_mid_busy", {31'd0, ifc.busy}, 32'd0);
    check("rst_mid_sb_empty", sb.size(), 32'd0);
    begin_scn();
    for (int i = 0; i < N; i++) begin
      rq_data[i].push_back(32'h6100_0000 + i);
      rq_last[i].push_back(1'b1);
      sb.push_back(32'h6100_0000 + i);
    end
    run_drain("post_rst", 40);
    check_seg("post_rst", 0, 4'b0001, 1, 1, 1);
    check_seg("post_rst", 3, 4'b1000, 1, 1, 1);

    check("final_sb_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
